// File: rtl/mem_pkg.sv
// Shared definitions for the datamem arbiter: bus widths, FSM state encoding,
// requester port IDs, RISC-V funct3 access codes and the latched memory
// request payload.
package mem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned F3_W   = 3;

  // Arbiter FSM encoding; 2'b11 is illegal and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_BUSY_I = 2'b01,
    ST_BUSY_D = 2'b10
  } state_e;

  // Requester IDs, also used as bit positions in request/grant vectors.
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Load/store funct3 codes understood by datamem.
  localparam logic [F3_W-1:0] FUNC3_LB  = 3'b000;
  localparam logic [F3_W-1:0] FUNC3_LH  = 3'b001;
  localparam logic [F3_W-1:0] FUNC3_LW  = 3'b010;
  localparam logic [F3_W-1:0] FUNC3_LBU = 3'b100;
  localparam logic [F3_W-1:0] FUNC3_LHU = 3'b101;
  localparam logic [F3_W-1:0] FUNC3_SB  = 3'b000;
  localparam logic [F3_W-1:0] FUNC3_SH  = 3'b001;
  localparam logic [F3_W-1:0] FUNC3_SW  = 3'b010;

  // Request payload held toward datamem for the life of a transaction.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [F3_W-1:0]   func3;
    logic              we;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  localparam mem_req_t MEM_REQ_RST = {ADDR_W'(0), FUNC3_LW, 1'b0, DATA_W'(0)};

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of every signal between the arbiter, the two cache-miss requesters
// (port I, port D) and datamem.
//   slave  : arbiter view (takes requests and memory responses).
//   master : environment view (requesters + datamem).
interface mem_arbiter_if;
  import mem_pkg::*;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_done;
  logic [DATA_W-1:0] i_rdata;
  logic              i_err;

  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_we;
  logic [F3_W-1:0]   d_func3;
  logic [DATA_W-1:0] d_wdata;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [F3_W-1:0]   mem_func3;
  logic              mem_write_en;
  logic [DATA_W-1:0] mem_store_val;
  logic [DATA_W-1:0] mem_load_val;
  logic              mem_data_ready;

  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_we, d_func3, d_wdata,
           mem_load_val, mem_data_ready,
    output i_done, i_rdata, i_err, d_done, d_rdata, d_err,
           mem_addr, mem_func3, mem_write_en, mem_store_val, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, d_we, d_func3, d_wdata,
           mem_load_val, mem_data_ready,
    input  i_done, i_rdata, i_err, d_done, d_rdata, d_err,
           mem_addr, mem_func3, mem_write_en, mem_store_val, busy
  );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker.
//   req_i        : request vector, bit PORT_I / PORT_D
//   last_grant_i : port granted most recently
//   gnt_c_o      : one-hot grant (all zero when nobody requests)
module rr_arb2
  import mem_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_c_o
);

  // On a tie, the port that did not win last time gets the grant.
  always_comb begin
    gnt_c_o = 2'b00;
    if (req_i[PORT_I] && req_i[PORT_D]) begin
      gnt_c_o[~last_grant_i] = 1'b1;
    end else begin
      gnt_c_o = req_i;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing one datamem between the instruction-fetch miss
// path (port I) and the data-cache miss/write-through path (port D).
// Latches one request, holds it on mem_* until data_ready or timeout, then
// returns a one-cycle done (with load data or an error flag).
//   clk, reset : clock, synchronous active-high reset
//   bus        : requester handshakes, datamem drive/response, busy
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic           clk,
  input  logic           reset,
  mem_arbiter_if.slave   bus
);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic              i_err_q, i_err_d;
  logic              d_err_q, d_err_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  mem_req_t          mem_q, mem_d;

  logic [1:0]        req_c;
  logic [1:0]        gnt_c;
  logic              timeout_c;
  logic              ready_c;

  // A port whose done is showing this cycle is still holding req; mask it so
  // it is not served twice.
  assign req_c[PORT_I] = bus.i_req & ~i_done_q;
  assign req_c[PORT_D] = bus.d_req & ~d_done_q;

  rr_arb2 u_rr_arb2 (
    .req_i        (req_c),
    .last_grant_i (last_grant_q),
    .gnt_c_o      (gnt_c)
  );

  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign ready_c   = bus.mem_data_ready;

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    i_err_d      = 1'b0;
    d_err_d      = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    mem_d        = mem_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt_c[PORT_D]) begin
          state_d      = ST_BUSY_D;
          mem_d        = '{addr: bus.d_addr, func3: bus.d_func3,
                           we: bus.d_we, wdata: bus.d_wdata};
          busy_d       = 1'b1;
          cnt_d        = '0;
          last_grant_d = PORT_D;
        end else if (gnt_c[PORT_I]) begin
          state_d      = ST_BUSY_I;
          mem_d.addr   = bus.i_addr;
          mem_d.func3  = FUNC3_LW;
          mem_d.we     = 1'b0;
          busy_d       = 1'b1;
          cnt_d        = '0;
          last_grant_d = PORT_I;
        end
      end

      ST_BUSY_I, ST_BUSY_D: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Ready beats a coincident timeout.
        if (ready_c || timeout_c) begin
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
          mem_d.we = 1'b0;
          if (state_q == ST_BUSY_I) begin
            i_done_d  = 1'b1;
            i_err_d   = ~ready_c;
            i_rdata_d = ready_c ? bus.mem_load_val : DATA_W'(0);
          end else begin
            d_done_d = 1'b1;
            d_err_d  = ~ready_c;
            if (!ready_c) begin
              d_rdata_d = DATA_W'(0);
            end else if (!mem_q.we) begin
              d_rdata_d = bus.mem_load_val;
            end
          end
        end
      end

      default: begin
        state_d      = ST_IDLE;
        last_grant_d = PORT_I;
        cnt_d        = '0;
        busy_d       = 1'b0;
        i_rdata_d    = DATA_W'(0);
        d_rdata_d    = DATA_W'(0);
        mem_d        = MEM_REQ_RST;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT_I;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      i_err_q      <= 1'b0;
      d_err_q      <= 1'b0;
      i_rdata_q    <= DATA_W'(0);
      d_rdata_q    <= DATA_W'(0);
      mem_q        <= MEM_REQ_RST;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      i_err_q      <= i_err_d;
      d_err_q      <= d_err_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      mem_q        <= mem_d;
    end
  end

  assign bus.i_done        = i_done_q;
  assign bus.i_rdata       = i_rdata_q;
  assign bus.i_err         = i_err_q;
  assign bus.d_done        = d_done_q;
  assign bus.d_rdata       = d_rdata_q;
  assign bus.d_err         = d_err_q;
  assign bus.mem_addr      = mem_q.addr;
  assign bus.mem_func3     = mem_q.func3;
  assign bus.mem_write_en  = mem_q.we;
  assign bus.mem_store_val = mem_q.wdata;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a table of per-cycle vectors for the
// basic I read and D-store-then-I sequences, then hand-written sequences for
// round-robin, timeout, mid-transaction reset and the re-grant guard.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_we;
    logic [2:0]  d_func3;
    logic [31:0] d_wdata;
    logic        rdy;
    logic [31:0] ld;
    logic        busy;
    logic        i_done;
    logic        i_err;
    logic        d_done;
    logic        d_err;
    logic [31:0] maddr;
    logic        mwe;
    logic [31:0] i_rdata;
    logic [31:0] d_rdata;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_addr = '0; bus.d_we = 1'b0;
    bus.d_func3 = 3'b010; bus.d_wdata = '0;
    bus.mem_load_val = '0; bus.mem_data_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    reset = 1'b0;
  endtask

  logic [31:0] got [$];
  logic [31:0] exp_rr [4];
  int          found;
  logic        prev_busy;

  initial begin
    // in: i_req i_addr d_req d_addr d_we f3 wdata rdy ld | out: busy id ie dd de maddr we ir dr
    tbl[0]  = '{1'b1, 32'h100, 1'b0, 32'h0,  1'b0, 3'b010, 32'h0,        1'b0, 32'h0,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 1'b0, 32'h0,        32'h0};
    tbl[1]  = '{1'b1, 32'h100, 1'b0, 32'h0,  1'b0, 3'b010, 32'h0,        1'b0, 32'h0,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 1'b0, 32'h0,        32'h0};
    tbl[2]  = tbl[1];
    tbl[3]  = tbl[1];
    tbl[4]  = '{1'b1, 32'h100, 1'b0, 32'h0,  1'b0, 3'b010, 32'h0,        1'b1, 32'hDEADBEEF,
                1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 1'b0, 32'hDEADBEEF, 32'h0};
    tbl[5]  = '{1'b0, 32'h100, 1'b0, 32'h0,  1'b0, 3'b010, 32'h0,        1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 1'b0, 32'hDEADBEEF, 32'h0};
    tbl[6]  = '{1'b1, 32'h200, 1'b1, 32'h40, 1'b1, 3'b010, 32'h12345678, 1'b0, 32'h0,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40,  1'b1, 32'hDEADBEEF, 32'h0};
    tbl[7]  = tbl[6];
    tbl[8]  = '{1'b1, 32'h200, 1'b1, 32'h40, 1'b1, 3'b010, 32'h12345678, 1'b1, 32'hAAAAAAAA,
                1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40,  1'b0, 32'hDEADBEEF, 32'h0};
    tbl[9]  = '{1'b1, 32'h200, 1'b0, 32'h40, 1'b1, 3'b010, 32'h12345678, 1'b0, 32'h0,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h200, 1'b0, 32'hDEADBEEF, 32'h0};
    tbl[10] = '{1'b1, 32'h200, 1'b0, 32'h40, 1'b0, 3'b010, 32'h0,        1'b1, 32'h0BADF00D,
                1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 1'b0, 32'h0BADF00D, 32'h0};
    tbl[11] = '{1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 3'b010, 32'h0,        1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h200, 1'b0, 32'h0BADF00D, 32'h0};

    // Reset values
    do_reset();
    chk("rst.busy",   32'(bus.busy), 32'h0);
    chk("rst.i_done", 32'(bus.i_done), 32'h0);
    chk("rst.d_done", 32'(bus.d_done), 32'h0);
    chk("rst.errs",   32'({bus.i_err, bus.d_err}), 32'h0);
    chk("rst.we",     32'(bus.mem_write_en), 32'h0);
    chk("rst.addr",   bus.mem_addr, 32'h0);
    chk("rst.func3",  32'(bus.mem_func3), 32'h2);
    chk("rst.store",  bus.mem_store_val, 32'h0);
    chk("rst.rdata",  bus.i_rdata | bus.d_rdata, 32'h0);

    // Table: I read, then simultaneous D store / I read
    for (int k = 0; k < 12; k++) begin
      bus.i_req = tbl[k].i_req;   bus.i_addr = tbl[k].i_addr;
      bus.d_req = tbl[k].d_req;   bus.d_addr = tbl[k].d_addr;
      bus.d_we  = tbl[k].d_we;    bus.d_func3 = tbl[k].d_func3;
      bus.d_wdata = tbl[k].d_wdata;
      bus.mem_data_ready = tbl[k].rdy; bus.mem_load_val = tbl[k].ld;
      step();
      chk($sformatf("v%0d.busy", k),    32'(bus.busy),         32'(tbl[k].busy));
      chk($sformatf("v%0d.i_done", k),  32'(bus.i_done),       32'(tbl[k].i_done));
      chk($sformatf("v%0d.i_err", k),   32'(bus.i_err),        32'(tbl[k].i_err));
      chk($sformatf("v%0d.d_done", k),  32'(bus.d_done),       32'(tbl[k].d_done));
      chk($sformatf("v%0d.d_err", k),   32'(bus.d_err),        32'(tbl[k].d_err));
      chk($sformatf("v%0d.maddr", k),   bus.mem_addr,          tbl[k].maddr);
      chk($sformatf("v%0d.we", k),      32'(bus.mem_write_en), 32'(tbl[k].mwe));
      chk($sformatf("v%0d.i_rdata", k), bus.i_rdata,           tbl[k].i_rdata);
      chk($sformatf("v%0d.d_rdata", k), bus.d_rdata,           tbl[k].d_rdata);
      if (k == 6) chk("v6.store", bus.mem_store_val, 32'h12345678);
    end

    // Round robin with both ports requesting continuously
    do_reset();
    exp_rr[0] = 32'h400; exp_rr[1] = 32'h300; exp_rr[2] = 32'h400; exp_rr[3] = 32'h300;
    bus.i_req = 1'b1; bus.i_addr = 32'h300;
    bus.d_req = 1'b1; bus.d_addr = 32'h400; bus.d_we = 1'b0;
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      prev_busy = bus.busy;
      bus.mem_data_ready = bus.busy;
      step();
      if (!prev_busy && bus.busy) got.push_back(bus.mem_addr);
    end
    chk("rr.count", 32'(got.size()), 32'd4);
    for (int k = 0; k < got.size() && k < 4; k++)
      chk($sformatf("rr.grant%0d", k), got[k], exp_rr[k]);
    bus.i_req = 1'b0; bus.d_req = 1'b0; bus.mem_data_ready = 1'b1;
    step();
    bus.mem_data_ready = 1'b0;
    step();

    // Timeout after a successful D load
    do_reset();
    bus.d_req = 1'b1; bus.d_addr = 32'h80; bus.d_we = 1'b0;
    step();
    bus.mem_data_ready = 1'b1; bus.mem_load_val = 32'h55AA55AA;
    step();
    chk("to.pre_done",  32'(bus.d_done), 32'h1);
    chk("to.pre_rdata", bus.d_rdata, 32'h55AA55AA);
    bus.d_req = 1'b0; bus.mem_data_ready = 1'b0;
    step();
    bus.d_req = 1'b1; bus.d_addr = 32'h84;
    found = 0;
    for (int c = 1; c <= 20 && found == 0; c++) begin
      step();
      if (bus.d_done) begin
        found = c;
        chk("to.err",   32'(bus.d_err), 32'h1);
        chk("to.rdata", bus.d_rdata, 32'h0);
        chk("to.busy",  32'(bus.busy), 32'h0);
        bus.d_req = 1'b0;
      end
    end
    chk("to.latency", 32'(found), 32'd9);
    bus.d_req = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h104;
    step();
    chk("to.next_busy", 32'(bus.busy), 32'h1);
    chk("to.next_addr", bus.mem_addr, 32'h104);
    bus.mem_data_ready = 1'b1; bus.mem_load_val = 32'h11111111;
    step();
    chk("to.next_done",  32'(bus.i_done), 32'h1);
    chk("to.next_err",   32'(bus.i_err), 32'h0);
    chk("to.next_rdata", bus.i_rdata, 32'h11111111);
    bus.i_req = 1'b0; bus.mem_data_ready = 1'b0;
    step();

    // Reset in the middle of a D store
    do_reset();
    bus.d_req = 1'b1; bus.d_addr = 32'h44; bus.d_we = 1'b1;
    bus.d_func3 = 3'b000; bus.d_wdata = 32'hCAFE;
    step();
    chk("rs.we1",    32'(bus.mem_write_en), 32'h1);
    chk("rs.func3a", 32'(bus.mem_func3), 32'h0);
    step();
    reset = 1'b1;
    step();
    chk("rs.we0",    32'(bus.mem_write_en), 32'h0);
    chk("rs.busy0",  32'(bus.busy), 32'h0);
    chk("rs.done0",  32'(bus.d_done), 32'h0);
    chk("rs.func3b", 32'(bus.mem_func3), 32'h2);
    reset = 1'b0;
    step();
    chk("rs.regrant", 32'(bus.busy), 32'h1);
    chk("rs.addr",    bus.mem_addr, 32'h44);
    chk("rs.we2",     32'(bus.mem_write_en), 32'h1);
    bus.mem_data_ready = 1'b1;
    step();
    chk("rs.done1", 32'(bus.d_done), 32'h1);
    bus.d_req = 1'b0; bus.mem_data_ready = 1'b0;
    step();

    // Re-grant guard: i_req held one cycle past done, then dropped
    do_reset();
    bus.i_req = 1'b1; bus.i_addr = 32'h500;
    step();
    bus.mem_data_ready = 1'b1; bus.mem_load_val = 32'h77;
    step();
    chk("rg.done", 32'(bus.i_done), 32'h1);
    bus.mem_data_ready = 1'b0;
    step();
    chk("rg.masked", 32'(bus.busy), 32'h0);
    bus.i_req = 1'b0;
    step();
    chk("rg.idle1", 32'(bus.busy), 32'h0);
    step();
    chk("rg.idle2", 32'(bus.busy | bus.i_done), 32'h0);

    // Re-grant guard: i_req still high the cycle after done -> new grant
    bus.i_req = 1'b1; bus.i_addr = 32'h504;
    step();
    bus.mem_data_ready = 1'b1;
    step();
    chk("rg2.done", 32'(bus.i_done), 32'h1);
    bus.mem_data_ready = 1'b0;
    step();
    chk("rg2.masked", 32'(bus.busy), 32'h0);
    step();
    chk("rg2.grant", 32'(bus.busy), 32'h1);
    chk("rg2.addr",  bus.mem_addr, 32'h504);
    bus.mem_data_ready = 1'b1;
    step();
    bus.i_req = 1'b0; bus.mem_data_ready = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
